// File: rtl/global_core_control_pkg.sv
// ISA definitions shared by the global sequencer: widths, opcodes, decode helpers.
package global_core_control_pkg;

  localparam int program_counter_length = 8;
  localparam int stack_pointer_length   = 4;
  localparam int instruction_length     = 32;

  typedef logic [program_counter_length-1:0] pc_t;
  typedef logic [stack_pointer_length-1:0]   sp_t;
  typedef logic [instruction_length-1:0]     instruction_t;

  // Encoding: opcode in [31:24], immediate in [15:0].
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_BRZ  = 8'h01;
  localparam logic [7:0] OP_JMP  = 8'h02;
  localparam logic [7:0] OP_CALL = 8'h03;
  localparam logic [7:0] OP_RET  = 8'h04;
  localparam logic [7:0] OP_HALT = 8'h05;
  localparam logic [7:0] OP_ADD  = 8'h10;

  // Next-PC decision for the instruction currently in EXEC.
  typedef struct packed {
    pc_t  pc;
    sp_t  sp;
    logic push;
    logic fault;
    logic halt;
  } next_t;

  function automatic logic is_cond_branch(instruction_t i);
    return i[31:24] == OP_BRZ;
  endfunction

  function automatic logic is_jump(instruction_t i);
    return i[31:24] == OP_JMP;
  endfunction

  function automatic logic is_call(instruction_t i);
    return i[31:24] == OP_CALL;
  endfunction

  function automatic logic is_return(instruction_t i);
    return i[31:24] == OP_RET;
  endfunction

  function automatic logic is_halt(instruction_t i);
    return i[31:24] == OP_HALT;
  endfunction

  function automatic pc_t imm(instruction_t i);
    return i[program_counter_length-1:0];
  endfunction

endpackage

// File: rtl/global_core_control_return_stack.sv
// Return-address stack: one synchronous write port at sp, async read of the top entry (sp-1).
module global_core_control_return_stack
  import global_core_control_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              push,
  input  logic [stack_pointer_length-1:0]   sp,
  input  logic [program_counter_length-1:0] push_data,
  output logic [program_counter_length-1:0] top
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  pc_t          mem [STACK_DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = AW'(sp);
  assign rd_idx = AW'(sp - sp_t'(1));

  // Contents need no reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push && (sp < sp_t'(STACK_DEPTH))) mem[wr_idx] <= push_data;
  end

  assign top = ((sp != '0) && (sp <= sp_t'(STACK_DEPTH))) ? mem[rd_idx] : '0;

endmodule

// File: rtl/global_core_control.sv
// Global sequencer: FETCH/EXEC loop, branch resolution from diverge, call/return stack.
// Optional build macro GLOBAL_CORE_CONTROL_PERF_EN adds saturating perf counters.
module global_core_control
  import global_core_control_pkg::*;
#(
  parameter int N_CELLS     = 16,
  parameter int STACK_DEPTH = 8,
  parameter int START_PC    = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic                              imem_rd_en,
  output logic [program_counter_length-1:0] imem_addr,
  input  logic [instruction_length-1:0]     imem_data,
  output logic [instruction_length-1:0]     instruction,
  output logic                              global_enable,
  input  logic [N_CELLS-1:0]                diverge,
  output logic [program_counter_length-1:0] next_program_counter,
  output logic [stack_pointer_length-1:0]   next_stack_pointer
`ifdef GLOBAL_CORE_CONTROL_PERF_EN
  ,
  output logic [31:0]                       perf_instr_count,
  output logic [31:0]                       perf_diverge_count
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} ctrl_state_t;

  ctrl_state_t  state_q, state_d;
  pc_t          pc_q, stack_top;
  sp_t          sp_q;
  instruction_t instr_q;
  next_t        nxt;
  logic         launch;

  // start only counts when idle/done as seen from registered state
  assign launch = start && ((state_q == IDLE) || (state_q == DONE));

  global_core_control_return_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .push      (nxt.push),
    .sp        (sp_q),
    .push_data (pc_q + pc_t'(1)),
    .top       (stack_top)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: HALT or a stack fault retires into DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (launch) state_d = FETCH;
      FETCH:      state_d = EXEC;
      EXEC:       state_d = (nxt.halt || nxt.fault) ? DONE : FETCH;
      default:    state_d = IDLE;
    endcase
  end

  // Next PC/SP for the instruction on imem_data; diverge matters only for BRZ
  always_comb begin
    nxt      = '0;
    nxt.pc   = pc_q + pc_t'(1);
    nxt.sp   = sp_q;
    if (is_cond_branch(imem_data)) begin
      if (&diverge) nxt.pc = imm(imem_data);
    end else if (is_jump(imem_data)) begin
      nxt.pc = imm(imem_data);
    end else if (is_call(imem_data)) begin
      if (sp_q == sp_t'(STACK_DEPTH)) begin
        nxt.fault = 1'b1;
        nxt.pc    = pc_q;
      end else begin
        nxt.push = (state_q == EXEC);
        nxt.sp   = sp_q + sp_t'(1);
        nxt.pc   = imm(imem_data);
      end
    end else if (is_return(imem_data)) begin
      if (sp_q == '0) begin
        nxt.fault = 1'b1;
        nxt.pc    = pc_q;
      end else begin
        nxt.pc = stack_top;
        nxt.sp = sp_q - sp_t'(1);
      end
    end else if (is_halt(imem_data)) begin
      nxt.pc   = pc_q;
      nxt.halt = 1'b1;
    end
  end

  // PC/SP/error/instruction registers; a fault freezes PC and SP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= pc_t'(START_PC);
      sp_q    <= '0;
      error   <= 1'b0;
      instr_q <= '0;
    end else if (launch) begin
      pc_q  <= pc_t'(START_PC);
      sp_q  <= '0;
      error <= 1'b0;
    end else if (state_q == EXEC) begin
      instr_q <= imem_data;
      if (nxt.fault) begin
        error <= 1'b1;
      end else begin
        pc_q <= nxt.pc;
        sp_q <= nxt.sp;
      end
    end
  end

  // Outputs from registered state; imem_data is the memory's registered read
  // port, so cells see it directly during EXEC and instr_q holds it afterwards.
  always_comb begin
    busy                 = 1'b0;
    done                 = 1'b0;
    global_enable        = 1'b0;
    imem_rd_en           = 1'b0;
    imem_addr            = '0;
    next_program_counter = '0;
    next_stack_pointer   = '0;
    instruction          = instr_q;
    unique case (state_q)
      FETCH: begin
        busy       = 1'b1;
        imem_rd_en = 1'b1;
        imem_addr  = pc_q;
      end
      EXEC: begin
        busy                 = 1'b1;
        global_enable        = 1'b1;
        instruction          = imem_data;
        next_program_counter = nxt.pc;
        next_stack_pointer   = nxt.sp;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef GLOBAL_CORE_CONTROL_PERF_EN
  logic mixed;
  assign mixed = is_cond_branch(imem_data) && (|diverge) && !(&diverge);

  // Saturating counters of executed instructions and divergent branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_count   <= '0;
      perf_diverge_count <= '0;
    end else if (launch) begin
      perf_instr_count   <= '0;
      perf_diverge_count <= '0;
    end else if (state_q == EXEC) begin
      if (perf_instr_count != '1) perf_instr_count <= perf_instr_count + 32'd1;
      if (mixed && (perf_diverge_count != '1))
        perf_diverge_count <= perf_diverge_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/global_core_control.md
Name: global_core_control

Overview:
- Central sequencer for the cell array. Fetches instructions from program memory, broadcasts each one to all cells, and gates their execution with global_enable.
- Resolves conditional branches from the per-cell diverge vector, and maintains the global program counter plus a return-address stack.
- Drives next_program_counter and next_stack_pointer, which cells compare against to reconverge.

Parameters:
- N_CELLS, 16, number of cell cores; width of the diverge vector.
- STACK_DEPTH, 8, return-address stack entries; must be <= 2**stack_pointer_length - 1.
- START_PC, 0, PC loaded on each start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run from START_PC when IDLE or DONE.
- busy  out  1  high in FETCH/EXEC.
- done  out  1  high in DONE (HALT retired).
- error  out  1  sticky until next start; stack overflow or underflow.
- imem_rd_en  out  1  program memory read strobe.
- imem_addr  out  program_counter_length  fetch address.
- imem_data  in  instruction_length  instruction; valid the cycle after imem_rd_en.
- instruction  out  instruction_length  registered broadcast instruction.
- global_enable  out  1  high only in EXEC.
- diverge  in  N_CELLS  per-cell divergence flags; sampled in EXEC.
- next_program_counter  out  program_counter_length  PC after the current instruction; valid in EXEC.
- next_stack_pointer  out  stack_pointer_length  SP after the current instruction; valid in EXEC.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=START_PC, sp=0, all outputs 0, stack contents don't-care.
- FSM states: IDLE, FETCH, EXEC, DONE.
- IDLE/DONE --start--> FETCH. Clears error, pc=START_PC, sp=0.
- FETCH: imem_rd_en=1, imem_addr=pc; unconditionally goes to EXEC.
- EXEC: instruction register = imem_data, global_enable=1. On the EXEC→FETCH edge, pc<=next_program_counter and sp<=next_stack_pointer.
- Throughput: one instruction per 2 cycles.
- next PC/SP selection in EXEC, by opcode via isa helpers; imm = immediate truncated to program_counter_length:
  - Conditional branch, &diverge=1 (uniform taken): next_pc=imm, sp unchanged.
  - Conditional branch, otherwise (mixed or none): next_pc=pc+1. Divergent cells park until the global PC reaches imm.
  - Unconditional jump: next_pc=imm.
  - CALL: push pc+1 at stack[sp], next_sp=sp+1, next_pc=imm.
  - RET: next_pc=stack[sp-1], next_sp=sp-1.
  - HALT: next_pc=pc, transition EXEC→DONE.
  - Any other opcode: next_pc=pc+1.
- PC arithmetic wraps modulo 2**program_counter_length; no trap on wrap.
- CALL with sp==STACK_DEPTH: error=1, no push, EXEC→DONE.
- RET with sp==0: error=1, EXEC→DONE.
- start while busy: ignored.
- start in the same cycle DONE is entered: ignored; must be re-pulsed.
- diverge is ignored outside EXEC and for non-conditional opcodes.
- done/busy/global_enable are decoded from registered state only (glitch-free).
- rst_n low mid-run: immediate return to IDLE; outputs cleared asynchronously.

Optional Feature:
- Macro: GLOBAL_CORE_CONTROL_PERF_EN.
- Defined: adds outputs perf_instr_count and perf_diverge_count (32 bits each, saturating).
  - perf_instr_count increments once per EXEC.
  - perf_diverge_count increments once per conditional-branch EXEC with diverge neither all-0 nor all-1.
  - Both cleared on reset and on start.
- Undefined: ports and counters absent; other behaviour identical.

Decomposition:
- In isa package: pc_t, sp_t, instruction_t, opcode helpers, plus added is_call, is_return and is_halt functions.
- Local: ctrl_state_t enum, kept in the module.
- One sub-module: return_stack (STACK_DEPTH x pc_t register file, one write port, one async read port at sp-1). FSM and next-PC logic stay in global_core_control.

Test Plan:
- Reset, then start with program {NOP, NOP, HALT} at 0 → imem_addr 0,1,2; global_enable pulses 3 times; done=1 after 6 cycles; error=0.
- BRZ imm=10 at pc=3 with diverge=all 1s → next_program_counter=10 during EXEC, next fetch at 10.
- Same BRZ with diverge=16'h00F0 → next_program_counter=4 (with PERF_EN, perf_diverge_count=1). Execution continues linearly to 10.
- CALL imm=20 at pc=5, then RET at 20 → sp 0→1→0; return fetch at 6; next_stack_pointer=1 during the CALL EXEC.
- 9 nested CALLs with STACK_DEPTH=8 → error=1, done=1 after the 9th; RET at sp=0 → error=1.
- rst_n low while in EXEC → global_enable, busy, imem_rd_en 0 in the same cycle (asynchronous); next start refetches from START_PC.
